quot_bcd_conv: RTL

//   Downstream stage of the 16-bit binary divider: takes the unsigned binary quotient
//   and converts it to packed BCD digits for the display/readout path.

---
 rtl/quot_bcd_conv_if.sv | 30 +++
 rtl/quot_bcd_conv.sv | 127 ++++++++++++
 2 files changed

// File: rtl/quot_bcd_conv_if.sv
`default_nettype none
// ============================================================================
//  Module      : quot_bcd_conv_if
//  Description : Operand-in / BCD-out valid-ready bundle for quot_bcd_conv.
//  Revision    : 1.0 - initial release
// ============================================================================
interface quot_bcd_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out
  );

  // Converter side
  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out
  );
endinterface
`default_nettype wire

// File: rtl/quot_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : quot_bcd_conv
//  Description : Sequential double-dabble binary-to-packed-BCD converter,
//                one input bit per clock, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module quot_bcd_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  quot_bcd_conv_if.slave    s_if,
  output logic              o_busy
);

  localparam int c_BCDW = 4 * DIGITS;
  localparam int c_CNTW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned c_MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned c_DEC_RANGE = pow10(DIGITS);

  // The top digit can only stay <= 9 if DIGITS covers the full binary range
  if (c_DEC_RANGE <= c_MAX_BIN) begin : g_digits_check
    $error("quot_bcd_conv: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [WIDTH-1:0]    r_shift;
  logic [c_BCDW-1:0]   r_bcd;
  logic [c_BCDW-1:0]   r_bcd_out;
  logic [c_CNTW-1:0]   r_cnt;

  logic                w_load;
  logic                w_step;
  logic                w_last;
  logic [c_BCDW-1:0]   w_adj;
  logic [c_BCDW-1:0]   w_next_bcd;

  // Add-3 correction applied per digit, no carry between digits
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig                = r_bcd[4*gi +: 4];
    assign w_adj[4*gi +: 4]     = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
  end

  assign w_next_bcd = {w_adj[c_BCDW-2:0], r_shift[WIDTH-1]};

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_if.in_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (r_cnt == c_CNTW'(1)) begin
          w_last       = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (s_if.out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_bcd_out <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_shift <= s_if.bin_in;
        r_bcd   <= '0;
        r_cnt   <= c_CNTW'(WIDTH);
      end else if (w_step) begin
        r_shift <= r_shift << 1;
        r_bcd   <= w_next_bcd;
        r_cnt   <= r_cnt - c_CNTW'(1);
      end
      // Only the completed value reaches the output register
      if (w_last) begin
        r_bcd_out <= w_next_bcd;
      end
    end
  end

  assign s_if.in_ready  = (r_state == ST_IDLE);
  assign s_if.out_valid = (r_state == ST_DONE);
  assign s_if.bcd_out   = r_bcd_out;
  assign o_busy         = (r_state == ST_SHIFT);

endmodule
`default_nettype wire
